soc: RTL and testbench

SOC -- requirements
Module: soc

---
 rtl/soc.sv | 148 ++++++++++++++
 tb/tb_soc.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/soc.sv
// Single-cycle RV32I-subset core: fetch, decode, execute and write back every rising clk.
// SOC_SHIFT_EN adds SLLI/SRLI/SRAI/SLL/SRL/SRA; without it those encodings execute as NOPs.

module soc_reg_file (
   input  logic        clk,
   input  logic        we,
   input  logic [4:0]  waddr,
   input  logic [31:0] wdata,
   input  logic [4:0]  raddr1,
   input  logic [4:0]  raddr2,
   output logic [31:0] rdata1,
   output logic [31:0] rdata2
);
   logic [31:0] memory [0:31];

   // No reset: register contents survive reset. Entry 0 is never written.
   always_ff @(posedge clk) begin
      if (we && (waddr != 5'd0))
         memory[waddr] <= wdata;
   end

   assign rdata1 = (raddr1 == 5'd0) ? 32'd0 : memory[raddr1];
   assign rdata2 = (raddr2 == 5'd0) ? 32'd0 : memory[raddr2];
endmodule

module soc_single_instr (
   input logic        clk,
   input logic        reset,
   input logic [31:0] instr
);
   logic [6:0]  opcode;
   logic [4:0]  rd;
   logic [2:0]  funct3;
   logic [4:0]  rs1;
   logic [4:0]  rs2;
   logic [6:0]  funct7;
   logic [31:0] imm;
   logic [31:0] rs1_data;
   logic [31:0] rs2_data;
   logic [31:0] result;
   logic        dec_we;
   logic        wr_en;

   assign opcode = instr[6:0];
   assign rd     = instr[11:7];
   assign funct3 = instr[14:12];
   assign rs1    = instr[19:15];
   assign rs2    = instr[24:20];
   assign funct7 = instr[31:25];
   assign imm    = {{20{instr[31]}}, instr[31:20]};

   always_comb begin
      dec_we = 1'b0;
      result = 32'd0;
      case (opcode)
         7'b0010011: begin
            dec_we = 1'b1;
            case (funct3)
               3'b000: result = rs1_data + imm;
               3'b010: result = {31'd0, $signed(rs1_data) < $signed(imm)};
               3'b011: result = {31'd0, rs1_data < imm};
               3'b100: result = rs1_data ^ imm;
               3'b110: result = rs1_data | imm;
               3'b111: result = rs1_data & imm;
`ifdef SOC_SHIFT_EN
               3'b001: begin
                  if (funct7 == 7'b0000000) result = rs1_data << rs2;
                  else                      dec_we = 1'b0;
               end
               3'b101: begin
                  if (funct7 == 7'b0000000)      result = rs1_data >> rs2;
                  else if (funct7 == 7'b0100000) result = $unsigned($signed(rs1_data) >>> rs2);
                  else                           dec_we = 1'b0;
               end
`endif
               default: dec_we = 1'b0;
            endcase
         end
         7'b0110011: begin
            dec_we = 1'b1;
            case ({funct7, funct3})
               {7'b0000000, 3'b000}: result = rs1_data + rs2_data;
               {7'b0100000, 3'b000}: result = rs1_data - rs2_data;
               {7'b0000000, 3'b111}: result = rs1_data & rs2_data;
               {7'b0000000, 3'b110}: result = rs1_data | rs2_data;
               {7'b0000000, 3'b100}: result = rs1_data ^ rs2_data;
               {7'b0000000, 3'b010}: result = {31'd0, $signed(rs1_data) < $signed(rs2_data)};
               {7'b0000000, 3'b011}: result = {31'd0, rs1_data < rs2_data};
`ifdef SOC_SHIFT_EN
               {7'b0000000, 3'b001}: result = rs1_data << rs2_data[4:0];
               {7'b0000000, 3'b101}: result = rs1_data >> rs2_data[4:0];
               {7'b0100000, 3'b101}: result = $unsigned($signed(rs1_data) >>> rs2_data[4:0]);
`endif
               default: dec_we = 1'b0;
            endcase
         end
         default: dec_we = 1'b0;
      endcase
   end

   // Reset low at the edge suppresses the write, so a reset pulse never commits a partial result.
   assign wr_en = dec_we & reset;

   soc_reg_file reg_mem (
      .clk    (clk),
      .we     (wr_en),
      .waddr  (rd),
      .wdata  (result),
      .raddr1 (rs1),
      .raddr2 (rs2),
      .rdata1 (rs1_data),
      .rdata2 (rs2_data)
   );
endmodule

module soc_cpu (
   input logic clk,
   input logic reset
);
   logic [31:0] program_memory [0:63];
   logic [31:0] pc;
   logic [31:0] instr;
   logic        unused_pc_bits;

   assign instr = program_memory[pc[7:2]];
   assign unused_pc_bits = ^{pc[31:8], pc[1:0]};

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) pc <= 32'd0;
      else        pc <= pc + 32'd4;
   end

   soc_single_instr single_instr (
      .clk   (clk),
      .reset (reset),
      .instr (instr)
   );
endmodule

module soc (
   input logic clk,
   input logic reset
);
   soc_cpu cpu (
      .clk   (clk),
      .reset (reset)
   );
endmodule

// File: tb/tb_soc.sv
// Bench for soc: directed programs plus a random program checked against an instruction-level model.
module tb_soc;
   logic clk = 1'b0;
   logic reset = 1'b0;
   int   errors = 0;
   int   checks = 0;

   always #5 clk = ~clk;

   soc dut (.clk(clk), .reset(reset));

   typedef enum int {K_ADDI, K_SLTI, K_SLTIU, K_XORI, K_ORI, K_ANDI,
                     K_ADD, K_SUB, K_AND, K_OR, K_XOR, K_SLT, K_SLTU,
                     K_SLLI, K_SRLI, K_SRAI, K_SLL, K_SRL, K_SRA, K_BAD} kind_e;
   typedef struct {kind_e k; int rd; int rs1; int rs2; int imm;} op_t;

   function automatic logic [31:0] enc_i(input int f3, input int rd, input int rs1, input int imm);
      logic [11:0] i12;
      logic [2:0]  f;
      logic [4:0]  d, s;
      i12 = imm[11:0]; f = f3[2:0]; d = rd[4:0]; s = rs1[4:0];
      return {i12, s, f, d, 7'b0010011};
   endfunction

   function automatic logic [31:0] enc_r(input int f7, input int f3, input int rd, input int rs1, input int rs2);
      logic [6:0] g; logic [2:0] f; logic [4:0] d, s1, s2;
      g = f7[6:0]; f = f3[2:0]; d = rd[4:0]; s1 = rs1[4:0]; s2 = rs2[4:0];
      return {g, s2, s1, f, d, 7'b0110011};
   endfunction

   function automatic logic [31:0] xr(input int i);
      return dut.cpu.single_instr.reg_mem.memory[i];
   endfunction

   task automatic load_and_start(input logic [31:0] p[$]);
      reset = 1'b0;
      @(negedge clk);
      for (int i = 0; i < 64; i++)
         dut.cpu.program_memory[i] = (i < p.size()) ? p[i] : 32'h0;
      @(negedge clk);
      reset = 1'b1;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      reset = 1'b0;
      repeat (3) @(negedge clk);
      checks++;
      if (dut.cpu.pc !== 32'd0) begin
         errors++; $display("FAIL reset_pc actual=%h required=0", dut.cpu.pc);
      end
   endtask

   task automatic test_imm_seq();
      logic [31:0] p[$];
      logic [31:0] exp5[5] = '{32'd120, 32'd200, 32'd2200, 32'd0, 32'd10};
      p = {enc_i(0, 5, 0, 120), enc_i(0, 5, 0, 200), enc_i(0, 5, 5, 2000),
           enc_i(7, 5, 0, -1), enc_i(6, 5, 0, 10)};
      load_and_start(p);
      for (int e = 0; e < 5; e++) begin
         step();
         checks++;
         if (xr(5) !== exp5[e]) begin
            errors++; $display("FAIL imm_seq edge%0d x5 actual=%h required=%h", e + 1, xr(5), exp5[e]);
         end
      end
   endtask

   task automatic test_add_sub();
      logic [31:0] p[$];
      p = {enc_i(0, 29, 0, 2), enc_i(0, 31, 0, 5), enc_r(0, 0, 5, 31, 29), enc_r(32, 0, 5, 31, 29)};
      load_and_start(p);
      step(); checks++;
      if (xr(29) !== 32'd2) begin errors++; $display("FAIL add_sub x29 actual=%h required=2", xr(29)); end
      step(); checks++;
      if (xr(31) !== 32'd5) begin errors++; $display("FAIL add_sub x31 actual=%h required=5", xr(31)); end
      step(); checks++;
      if (xr(5) !== 32'd7) begin errors++; $display("FAIL add_sub add x5 actual=%h required=7", xr(5)); end
      step(); checks++;
      if (xr(5) !== 32'd3) begin errors++; $display("FAIL add_sub sub x5 actual=%h required=3", xr(5)); end
   endtask

   task automatic test_sub_equal();
      logic [31:0] p[$];
      p = {enc_i(0, 6, 0, 99), enc_i(0, 10, 0, 2047), enc_i(0, 11, 0, 2047), enc_r(32, 0, 6, 11, 10)};
      load_and_start(p);
      repeat (3) step();
      checks++;
      if (xr(10) !== 32'd2047) begin errors++; $display("FAIL sub_eq x10 actual=%h required=7ff", xr(10)); end
      step(); checks++;
      if (xr(6) !== 32'd0) begin errors++; $display("FAIL sub_eq x6 edge4 actual=%h required=0", xr(6)); end
      repeat (3) step();
      checks++;
      if (xr(6) !== 32'd0) begin errors++; $display("FAIL sub_eq x6 edge7 actual=%h required=0", xr(6)); end
   endtask

   task automatic test_slt();
      logic [31:0] p[$];
      p = {enc_i(0, 7, 0, -1), enc_r(0, 3, 8, 0, 7), enc_r(0, 2, 9, 0, 7)};
      load_and_start(p);
      repeat (3) step();
      checks++;
      if (xr(7) !== 32'hFFFF_FFFF) begin errors++; $display("FAIL slt x7 actual=%h required=ffffffff", xr(7)); end
      checks++;
      if (xr(8) !== 32'd1) begin errors++; $display("FAIL sltu x8 actual=%h required=1", xr(8)); end
      checks++;
      if (xr(9) !== 32'd0) begin errors++; $display("FAIL slt x9 actual=%h required=0", xr(9)); end
   endtask

   task automatic test_x0();
      logic [31:0] p[$];
      p = {enc_i(0, 1, 0, 77), enc_i(0, 0, 0, 5), enc_r(0, 0, 1, 0, 0)};
      load_and_start(p);
      step(); checks++;
      if (xr(1) !== 32'd77) begin errors++; $display("FAIL x0 setup x1 actual=%h required=4d", xr(1)); end
      step(); checks++;
      if (xr(0) === 32'd5) begin errors++; $display("FAIL x0 write actual=%h required=not 5", xr(0)); end
      step(); checks++;
      if (xr(1) !== 32'd0) begin errors++; $display("FAIL x0 read x1 actual=%h required=0", xr(1)); end
   endtask

   task automatic test_mid_reset();
      logic [31:0] p[$];
      p = {enc_i(0, 12, 0, 1), enc_i(0, 12, 12, 1), enc_i(0, 12, 12, 1), enc_i(0, 12, 12, 1)};
      load_and_start(p);
      repeat (3) step();
      checks++;
      if (xr(12) !== 32'd3) begin errors++; $display("FAIL mid_reset pre x12 actual=%h required=3", xr(12)); end
      @(negedge clk);
      reset = 1'b0;
      #1; checks++;
      if (dut.cpu.pc !== 32'd0) begin errors++; $display("FAIL mid_reset pc actual=%h required=0", dut.cpu.pc); end
      step(); checks++;
      if (xr(12) !== 32'd3) begin errors++; $display("FAIL mid_reset held x12 actual=%h required=3", xr(12)); end
      @(negedge clk);
      reset = 1'b1;
      step(); checks++;
      if (xr(12) !== 32'd1) begin errors++; $display("FAIL mid_reset word0 x12 actual=%h required=1", xr(12)); end
      checks++;
      if (dut.cpu.pc !== 32'd4) begin errors++; $display("FAIL mid_reset pc after actual=%h required=4", dut.cpu.pc); end
   endtask

   function automatic logic [31:0] encode(input op_t o);
      case (o.k)
         K_ADDI:  return enc_i(0, o.rd, o.rs1, o.imm);
         K_SLTI:  return enc_i(2, o.rd, o.rs1, o.imm);
         K_SLTIU: return enc_i(3, o.rd, o.rs1, o.imm);
         K_XORI:  return enc_i(4, o.rd, o.rs1, o.imm);
         K_ORI:   return enc_i(6, o.rd, o.rs1, o.imm);
         K_ANDI:  return enc_i(7, o.rd, o.rs1, o.imm);
         K_ADD:   return enc_r(0, 0, o.rd, o.rs1, o.rs2);
         K_SUB:   return enc_r(32, 0, o.rd, o.rs1, o.rs2);
         K_AND:   return enc_r(0, 7, o.rd, o.rs1, o.rs2);
         K_OR:    return enc_r(0, 6, o.rd, o.rs1, o.rs2);
         K_XOR:   return enc_r(0, 4, o.rd, o.rs1, o.rs2);
         K_SLT:   return enc_r(0, 2, o.rd, o.rs1, o.rs2);
         K_SLTU:  return enc_r(0, 3, o.rd, o.rs1, o.rs2);
         K_SLLI:  return enc_i(1, o.rd, o.rs1, o.imm & 31);
         K_SRLI:  return enc_i(5, o.rd, o.rs1, o.imm & 31);
         K_SRAI:  return enc_i(5, o.rd, o.rs1, 32'h400 | (o.imm & 31));
         K_SLL:   return enc_r(0, 1, o.rd, o.rs1, o.rs2);
         K_SRL:   return enc_r(0, 5, o.rd, o.rs1, o.rs2);
         K_SRA:   return enc_r(32, 5, o.rd, o.rs1, o.rs2);
         default: return (o.imm[0]) ? enc_r(1, 0, o.rd, o.rs1, o.rs2)
                                    : {o.imm[11:0], 13'h0, 7'b0000011};
      endcase
   endfunction

   // Instruction-level semantics; returns 0 when the instruction writes nothing.
   function automatic bit model(input op_t o, input logic [31:0] a, input logic [31:0] b, output logic [31:0] r);
      logic [31:0] iv;
      int sh, shr;
      iv = o.imm;
      sh = o.imm & 31;
      shr = b & 31;
      r = 32'd0;
      case (o.k)
         K_ADDI:  r = a + iv;
         K_SLTI:  r = ($signed(a) < $signed(iv)) ? 32'd1 : 32'd0;
         K_SLTIU: r = (a < iv) ? 32'd1 : 32'd0;
         K_XORI:  r = a ^ iv;
         K_ORI:   r = a | iv;
         K_ANDI:  r = a & iv;
         K_ADD:   r = a + b;
         K_SUB:   r = a - b;
         K_AND:   r = a & b;
         K_OR:    r = a | b;
         K_XOR:   r = a ^ b;
         K_SLT:   r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
         K_SLTU:  r = (a < b) ? 32'd1 : 32'd0;
`ifdef SOC_SHIFT_EN
         K_SLLI:  r = a << sh;
         K_SRLI:  r = a >> sh;
         K_SRAI:  r = $signed(a) >>> sh;
         K_SLL:   r = a << shr;
         K_SRL:   r = a >> shr;
         K_SRA:   r = $signed(a) >>> shr;
`endif
         default: return 1'b0;
      endcase
`ifndef SOC_SHIFT_EN
      if (o.k inside {K_SLLI, K_SRLI, K_SRAI, K_SLL, K_SRL, K_SRA}) return 1'b0;
`endif
      return 1'b1;
   endfunction

   task automatic test_random();
      op_t         ops[64];
      logic [31:0] p[$];
      logic [31:0] mdl[32];
      logic [31:0] r;
      for (int i = 0; i < 64; i++) begin
         ops[i].imm = int'($urandom_range(0, 4095));
         if (ops[i].imm > 2047) ops[i].imm -= 4096;
         if (i < 31) begin
            ops[i].k = K_ADDI; ops[i].rd = i + 1; ops[i].rs1 = 0; ops[i].rs2 = 0;
         end else begin
            ops[i].k   = kind_e'($urandom_range(0, int'(K_BAD)));
            ops[i].rd  = int'($urandom_range(0, 31));
            ops[i].rs1 = int'($urandom_range(0, 31));
            ops[i].rs2 = int'($urandom_range(0, 31));
         end
         p.push_back(encode(ops[i]));
      end
      for (int i = 0; i < 32; i++) mdl[i] = 32'd0;
      load_and_start(p);
      for (int n = 1; n <= 72; n++) begin
         op_t o;
         o = ops[(n - 1) % 64];
         if (model(o, mdl[o.rs1], mdl[o.rs2], r) && o.rd != 0) mdl[o.rd] = r;
         step();
         checks++;
         if (dut.cpu.pc !== 32'(4 * n)) begin
            errors++; $display("FAIL rand_pc edge%0d actual=%h required=%h", n, dut.cpu.pc, 32'(4 * n));
         end
         // Registers become defined as the init block writes them in order.
         for (int j = 1; j < 32 && (n >= 31 || j <= n); j++) begin
            checks++;
            if (xr(j) !== mdl[j]) begin
               errors++; $display("FAIL rand_reg edge%0d x%0d kind=%0d actual=%h required=%h",
                                  n, j, int'(o.k), xr(j), mdl[j]);
            end
         end
      end
   endtask

   initial begin
      test_reset();
      test_imm_seq();
      test_add_sub();
      test_sub_equal();
      test_slt();
      test_x0();
      test_mid_reset();
      repeat (3) test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
